// File: rtl/divfrec_pkg.sv
// Shared types, defaults and the divisor clamp for the divfrec_multi clock divider.
package divfrec_pkg;

  localparam int unsigned DIVFREC_CNT_W_DEF   = 16;
  localparam int unsigned DIVFREC_DEFAULT_DIV = 500;
  localparam int unsigned DIVFREC_MIN_DIV     = 2;

  typedef struct packed {
    logic [DIVFREC_CNT_W_DEF-1:0] div;
    logic [DIVFREC_CNT_W_DEF-1:0] high;
  } divfrec_cfg_t;

  typedef enum logic {
    CH_IDLE,
    CH_RUN
  } divfrec_state_t;

  // A period shorter than two cycles cannot hold both a high and a low phase.
  function automatic divfrec_cfg_t divfrec_clamp(input divfrec_cfg_t c);
    divfrec_cfg_t r;
    r = c;
    if (c.div < DIVFREC_CNT_W_DEF'(DIVFREC_MIN_DIV))
      r.div = DIVFREC_CNT_W_DEF'(DIVFREC_MIN_DIV);
    return r;
  endfunction

endpackage

// File: rtl/divfrec_chan.sv
// One divider channel: shadow/active config pair, period counter, registered clk/tick.
// With DIVFREC_SYNC_EN defined, sync_i restarts a running channel at count 0.
module divfrec_chan
  import divfrec_pkg::*;
#(
  parameter int unsigned DEFAULT_DIV = DIVFREC_DEFAULT_DIV
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         load_i,
  input  divfrec_cfg_t cfg_i,
`ifdef DIVFREC_SYNC_EN
  input  logic         sync_i,
`endif
  output logic         clk_out_o,
  output logic         tick_o
);

  localparam int unsigned W = DIVFREC_CNT_W_DEF;
  localparam divfrec_cfg_t CFG_RST = '{div: W'(DEFAULT_DIV), high: W'(DEFAULT_DIV / 2)};

  divfrec_state_t state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  divfrec_cfg_t   shadow_q, shadow_d;
  divfrec_cfg_t   active_q, active_d;
  logic           clk_out_q, clk_out_d;
  logic           tick_q, tick_d;
  logic           wrap, restart, transfer;

  // cnt_q is the count of the cycle currently on the outputs; the _d values
  // describe the next output cycle, so clk_out/tick stay purely registered.
  always_comb begin
    shadow_d  = load_i ? cfg_i : shadow_q;
    wrap      = (cnt_q == active_q.div - W'(1));
    restart   = 1'b0;
`ifdef DIVFREC_SYNC_EN
    restart   = sync_i;
`endif
    transfer  = (state_q == CH_IDLE) || wrap || restart;
    active_d  = transfer ? divfrec_clamp(shadow_q) : active_q;
    state_d   = en_i ? CH_RUN : CH_IDLE;
    cnt_d     = '0;
    clk_out_d = 1'b0;
    tick_d    = 1'b0;
    if (en_i) begin
      cnt_d     = transfer ? '0 : cnt_q + W'(1);
      clk_out_d = (cnt_d < active_d.high);
      tick_d    = (cnt_d == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CH_IDLE;
      cnt_q     <= '0;
      shadow_q  <= CFG_RST;
      active_q  <= CFG_RST;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/divfrec_multi.sv
// Multi-channel programmable clock divider / tick generator (CNT_W up to 16).
// Optional macro DIVFREC_SYNC_EN adds the sync input for a phase-aligned restart.
module divfrec_multi
  import divfrec_pkg::*;
#(
  parameter int unsigned NCH         = 2,
  parameter int unsigned CNT_W       = DIVFREC_CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DIVFREC_DEFAULT_DIV
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NCH-1:0]                      en,
  input  logic                                load,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] load_ch,
  input  logic [CNT_W-1:0]                    div_in,
  input  logic [CNT_W-1:0]                    high_in,
`ifdef DIVFREC_SYNC_EN
  input  logic                                sync,
`endif
  output logic [NCH-1:0]                      clk_out,
  output logic [NCH-1:0]                      tick
);

  localparam int unsigned LCH_W = (NCH > 1) ? $clog2(NCH) : 1;

  divfrec_cfg_t load_cfg;

  assign load_cfg = '{div: DIVFREC_CNT_W_DEF'(div_in), high: DIVFREC_CNT_W_DEF'(high_in)};

  // load_ch values >= NCH match no channel and are dropped.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic load_s;
    assign load_s = load && (load_ch == LCH_W'(i));

    divfrec_chan #(
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .en_i     (en[i]),
      .load_i   (load_s),
      .cfg_i    (load_cfg),
`ifdef DIVFREC_SYNC_EN
      .sync_i   (sync),
`endif
      .clk_out_o(clk_out[i]),
      .tick_o   (tick[i])
    );
  end

endmodule
